// File: rtl/mem_stage_param_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_param_if
// Purpose : Execute->memory control/data bundle plus the M->W register outputs.
// Revision: 1.0  initial release
// ============================================================================
interface mem_stage_param_if #(
    parameter int REG_W = 5
);
    logic             validM;
    logic             regwriteM;
    logic             memtoregM;
    logic             memwriteM;
    logic             memreadM;
    logic [1:0]       memsizeM;
    logic             memsignedM;
    logic [31:0]      aluoutM;
    logic [31:0]      writedataM;
    logic [REG_W-1:0] writeregM;
    logic             stallM;
    logic             validW;
    logic             regwriteW;
    logic             memtoregW;
    logic             misalignW;
    logic [31:0]      readdataW;
    logic [31:0]      aluoutW;
    logic [REG_W-1:0] writeregW;

    modport master (
        output validM, regwriteM, memtoregM, memwriteM, memreadM,
        output memsizeM, memsignedM, aluoutM, writedataM, writeregM,
        input  stallM, validW, regwriteW, memtoregW, misalignW,
        input  readdataW, aluoutW, writeregW
    );

    modport slave (
        input  validM, regwriteM, memtoregM, memwriteM, memreadM,
        input  memsizeM, memsignedM, aluoutM, writedataM, writeregM,
        output stallM, validW, regwriteW, memtoregW, misalignW,
        output readdataW, aluoutW, writeregW
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_param
// Purpose : MIPS memory stage with byte-enabled data RAM, configurable access
//           latency with upstream stall, and the M->W pipeline register.
// Revision: 1.0  initial release
// ============================================================================
module mem_stage_param #(
    parameter int DEPTH_LOG2  = 8,
    parameter int MEM_LATENCY = 0,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    mem_stage_param_if.slave bus
);
    localparam int         c_depth    = 2 ** DEPTH_LOG2;
    localparam logic       c_has_wait = (MEM_LATENCY > 0);
    localparam logic [2:0] c_cnt_init = (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic                  w_stall;

    logic                  w_memop;
    logic                  w_misalign;
    logic                  w_access;
    logic                  w_we;
    logic                  w_load;
    logic [1:0]            w_lane;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ld_data;

    logic [31:0]           r_mem [0:c_depth-1];

    logic                  r_validW;
    logic                  r_regwriteW;
    logic                  r_memtoregW;
    logic                  r_misalignW;
    logic [31:0]           r_readdataW;
    logic [31:0]           r_aluoutW;
    logic [REG_W-1:0]      r_writeregW;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_lane     = bus.aluoutM[1:0];
    assign w_idx      = bus.aluoutM[DEPTH_LOG2+1:2];
    assign w_memop    = bus.validM & (bus.memreadM | bus.memwriteM);
    assign w_misalign = ((bus.memsizeM == 2'b01) & w_lane[0]) |
                        (bus.memsizeM[1] & (w_lane != 2'b00));
    assign w_access   = w_memop & ~w_misalign;
    // Commit/sample only in the completing (non-stalled) cycle; reset abandons it.
    assign w_we       = w_access & bus.memwriteM & ~w_stall & ~reset;
    assign w_load     = w_access & bus.memreadM;

    // ------------------------------------------------------------------
    // Latency FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && c_has_wait) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            S_WAIT: begin
                if (r_cnt != 3'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (reset) begin
            w_stall = 1'b0;
        end
    end

    assign bus.stallM = w_stall;

    // ------------------------------------------------------------------
    // Store lane steering: replicate the right-aligned data across lanes
    // and let the byte enables pick the destination.
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.writedataM;
        case (bus.memsizeM)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.writedataM[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.writedataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.writedataM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_we && w_be[k]) begin
                r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_ld_data = w_word;
        case (bus.memsizeM)
            2'b00:   w_ld_data = {{24{bus.memsignedM & w_byte[7]}}, w_byte};
            2'b01:   w_ld_data = {{16{bus.memsignedM & w_half[15]}}, w_half};
            default: w_ld_data = w_word;
        endcase
    end

    // ------------------------------------------------------------------
    // M->W pipeline register; a stall inserts a bubble and holds data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_validW    <= 1'b0;
            r_regwriteW <= 1'b0;
            r_memtoregW <= 1'b0;
            r_misalignW <= 1'b0;
            r_readdataW <= 32'h0;
            r_aluoutW   <= 32'h0;
            r_writeregW <= '0;
        end else if (w_stall) begin
            r_validW    <= 1'b0;
            r_regwriteW <= 1'b0;
            r_misalignW <= 1'b0;
        end else begin
            r_validW    <= bus.validM;
            r_regwriteW <= bus.validM & bus.regwriteM & ~(w_memop & w_misalign);
            r_memtoregW <= bus.memtoregM;
            r_misalignW <= w_memop & w_misalign;
            r_readdataW <= w_load ? w_ld_data : 32'h0;
            r_aluoutW   <= bus.aluoutM;
            r_writeregW <= bus.writeregM;
        end
    end

    assign bus.validW    = r_validW;
    assign bus.regwriteW = r_regwriteW;
    assign bus.memtoregW = r_memtoregW;
    assign bus.misalignW = r_misalignW;
    assign bus.readdataW = r_readdataW;
    assign bus.aluoutW   = r_aluoutW;
    assign bus.writeregW = r_writeregW;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_param
// Purpose : Directed scoreboard bench for mem_stage_param at latencies 0, 2, 3.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_stage_param;
    typedef struct {
        logic        v;
        logic        rw;
        logic        mtr;
        logic        mis;
        logic        chk_rd;
        logic        chk_alu;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          sel = 0;
    logic        valid = 1'b0, regw = 1'b0, mtr = 1'b0, mw = 1'b0, mr = 1'b0, sgn = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = 32'h0, wd = 32'h0;
    logic [4:0]  wreg = 5'h0;

    logic        stall_a [3];
    logic        valid_a [3];
    logic        rw_a    [3];
    logic        mtr_a   [3];
    logic        mis_a   [3];
    logic [31:0] rd_a    [3];
    logic [31:0] alu_a   [3];
    logic [4:0]  wr_a    [3];

    exp_t        sbq[$];
    int          passes = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    mem_stage_param_if #(.REG_W(5)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].validM     = valid && (sel == g);
        assign bus[g].regwriteM  = regw;
        assign bus[g].memtoregM  = mtr;
        assign bus[g].memwriteM  = mw;
        assign bus[g].memreadM   = mr;
        assign bus[g].memsizeM   = size;
        assign bus[g].memsignedM = sgn;
        assign bus[g].aluoutM    = addr;
        assign bus[g].writedataM = wd;
        assign bus[g].writeregM  = wreg;
        assign stall_a[g] = bus[g].stallM;
        assign valid_a[g] = bus[g].validW;
        assign rw_a[g]    = bus[g].regwriteW;
        assign mtr_a[g]   = bus[g].memtoregW;
        assign mis_a[g]   = bus[g].misalignW;
        assign rd_a[g]    = bus[g].readdataW;
        assign alu_a[g]   = bus[g].aluoutW;
        assign wr_a[g]    = bus[g].writeregW;

        mem_stage_param #(
            .DEPTH_LOG2 (8),
            .MEM_LATENCY((g == 0) ? 0 : (g == 1) ? 2 : 3),
            .REG_W      (5)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 2 : 3;
    endfunction

    function automatic logic mis_of(input logic [1:0] sz, input logic [31:0] a);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    endfunction

    // Drive one op, push its expectation, wait out any stall, then pop and compare.
    task automatic issue(input logic v, input logic rwi, input logic m2r, input logic mwr,
                         input logic mrd, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] wr,
                         input exp_t e);
        exp_t got;
        int   stalls;
        valid = v; regw = rwi; mtr = m2r; mw = mwr; mr = mrd;
        size = sz; sgn = sg; addr = a; wd = d; wreg = wr;
        sbq.push_back(e);
        stalls = 0;
        #1;
        while (stall_a[sel] && stalls < 20) begin
            if (stalls > 0) check("bubble_validW", 32'(valid_a[sel]), 32'h0);
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        got = sbq.pop_front();
        check("stall_cycles", 32'(stalls), 32'(got.stalls));
        check("validW", 32'(valid_a[sel]), 32'(got.v));
        check("regwriteW", 32'(rw_a[sel]), 32'(got.rw));
        check("memtoregW", 32'(mtr_a[sel]), 32'(got.mtr));
        check("misalignW", 32'(mis_a[sel]), 32'(got.mis));
        if (got.chk_rd) check("readdataW", rd_a[sel], got.rd);
        if (got.chk_alu) begin
            check("aluoutW", alu_a[sel], got.alu);
            check("writeregW", 32'(wr_a[sel]), 32'(got.wr));
        end
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e = '{v: 1'b1, rw: 1'b0, mtr: 1'b0, mis: mis_of(sz, a), chk_rd: 1'b0, chk_alu: 1'b0,
              rd: 32'h0, alu: 32'h0, wr: 5'h0, stalls: mis_of(sz, a) ? 0 : lat_of(sel)};
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sz, 1'b0, a, d, 5'd0, e);
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] exp_rd);
        exp_t e;
        logic m;
        m = mis_of(sz, a);
        e = '{v: 1'b1, rw: ~m, mtr: 1'b1, mis: m, chk_rd: ~m, chk_alu: 1'b0,
              rd: exp_rd, alu: 32'h0, wr: 5'h0, stalls: m ? 0 : lat_of(sel)};
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, sz, sg, a, 32'h0, 5'd8, e);
    endtask

    task automatic alu(input logic [31:0] a, input logic [4:0] wr);
        exp_t e;
        e = '{v: 1'b1, rw: 1'b1, mtr: 1'b0, mis: 1'b0, chk_rd: 1'b0, chk_alu: 1'b1,
              rd: 32'h0, alu: a, wr: wr, stalls: 0};
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, a, 32'h0, wr, e);
    endtask

    task automatic bub();
        exp_t e;
        e = '{v: 1'b0, rw: 1'b0, mtr: 1'b0, mis: 1'b0, chk_rd: 1'b0, chk_alu: 1'b0,
              rd: 32'h0, alu: 32'h0, wr: 5'h0, stalls: 0};
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 5'd3, e);
    endtask

    task automatic check_w_zero(input string tag);
        check({tag, "_validW"},    32'(valid_a[sel]), 32'h0);
        check({tag, "_regwriteW"}, 32'(rw_a[sel]),    32'h0);
        check({tag, "_memtoregW"}, 32'(mtr_a[sel]),   32'h0);
        check({tag, "_misalignW"}, 32'(mis_a[sel]),   32'h0);
        check({tag, "_readdataW"}, rd_a[sel],         32'h0);
        check({tag, "_aluoutW"},   alu_a[sel],        32'h0);
        check({tag, "_writeregW"}, 32'(wr_a[sel]),    32'h0);
        check({tag, "_stallM"},    32'(stall_a[sel]), 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        check_w_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Latency 0: word/sub-word stores and loads
        sel = 0;
        st(2'b10, 32'h10, 32'hDEADBEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        st(2'b00, 32'h13, 32'h12345680);
        ld(2'b10, 1'b0, 32'h10, 32'h80ADBEEF);
        ld(2'b00, 1'b1, 32'h13, 32'hFFFFFF80);
        ld(2'b00, 1'b0, 32'h13, 32'h00000080);
        st(2'b01, 32'h10, 32'hABCD1234);
        ld(2'b01, 1'b0, 32'h10, 32'h00001234);
        ld(2'b01, 1'b1, 32'h12, 32'hFFFF80AD);
        ld(2'b00, 1'b0, 32'h11, 32'h00000012);
        ld(2'b11, 1'b1, 32'h410, 32'h80AD1234);

        // Latency 0: back-to-back ALU ops and bubbles
        for (int i = 0; i < 10; i++) alu(32'h1000 + 32'(i * 7), 5'(i + 1));
        bub();
        bub();

        // Latency 2: stalls, held add, misaligned ops
        sel = 1;
        st(2'b10, 32'h20, 32'h55667788);
        ld(2'b10, 1'b0, 32'h20, 32'h55667788);
        alu(32'h00ABCDEF, 5'd9);
        ld(2'b01, 1'b1, 32'h11, 32'h0);
        ld(2'b10, 1'b0, 32'h22, 32'h0);
        st(2'b01, 32'h21, 32'h0000FFFF);
        ld(2'b10, 1'b0, 32'h20, 32'h55667788);
        ld(2'b00, 1'b1, 32'h21, 32'h00000077);

        // Latency 3: reset during a pending store abandons it
        sel = 2;
        st(2'b10, 32'h30, 32'h11112222);
        valid = 1'b1; regw = 1'b0; mtr = 1'b0; mw = 1'b1; mr = 1'b0;
        size = 2'b10; addr = 32'h30; wd = 32'hCAFEF00D; wreg = 5'd0;
        #1 check("sw30_stall_first", 32'(stall_a[sel]), 32'h1);
        @(posedge clk); #1;
        check("sw30_stall_second", 32'(stall_a[sel]), 32'h1);
        check("sw30_aluoutW_before", alu_a[sel], 32'h30);
        reset = 1'b1;
        #1 check_w_zero("midreset");
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ld(2'b10, 1'b0, 32'h30, 32'h11112222);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/mem_stage_param.md
# mem_stage_param

Parametrised MIPS memory stage with an integrated data memory and M→W pipeline register. It adds byte, halfword and word stores with byte enables, plus sign- and zero-extended sub-word loads. Memory latency is configurable; a stall handshake freezes upstream stages while an access is in flight, and misaligned accesses are flagged. It sits between the execute→memory pipeline register and the writeback stage.

## Interface
- DEPTH_LOG2, 8: data memory holds 2**DEPTH_LOG2 32-bit words.
- MEM_LATENCY, 0: extra wait cycles per load/store, 0..7. At 0 the block behaves as a single-cycle memory stage.
- REG_W, 5: register-file index width.
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- validM  in  1  M-stage slot holds a real instruction.
- regwriteM, memtoregM, memwriteM, memreadM  in  1 each  control from execute.
- memsizeM  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- memsignedM  in  1  1 sign-extends sub-word loads, 0 zero-extends.
- aluoutM  in  32  byte address for memory ops, result for ALU ops.
- writedataM  in  32  store data, right-aligned.
- writeregM  in  REG_W  destination register.
- stallM  out  1  combinational; upstream holds all M inputs while high.
- validW, regwriteW, memtoregW, misalignW  out  1 each  registered.
- readdataW, aluoutW  out  32  registered.
- writeregW  out  REG_W  registered.

## Operation
- Memory op = validM & (memreadM | memwriteM).
- Misaligned when halfword with aluoutM[0]=1, or word with aluoutM[1:0]≠00.
  - No array access and no stall.
  - W captures misalignW=1, regwriteW=0, validW=1.
- Word index = aluoutM[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.
- Byte lanes are little-endian; lane k covers bits [8k+7:8k].
- Stores:
  - Byte: writedataM[7:0] goes to lane aluoutM[1:0].
  - Halfword: writedataM[15:0] goes to lanes {aluoutM[1],0}+1..0.
  - Word: all four lanes.
  - Unselected lanes keep their contents.
- Loads: the selected lane(s) are right-aligned, then extended per memsignedM to form readdataW. Word loads ignore memsignedM.
- Non-memory ops and validM=0 pass straight to W with no stall.
- FSM:
  - IDLE: a memory op with MEM_LATENCY>0 that is aligned drives stallM=1 combinationally, loads cnt=MEM_LATENCY-1 and moves to WAIT.
  - WAIT: stallM=1 while cnt≠0, decrementing cnt each cycle. When cnt=0, stallM=0, the access completes and the FSM returns to IDLE.
- While stallM=1, W loads a bubble: validW=0, regwriteW=0, misalignW=0, other W outputs hold.
- Store commit and load sampling happen only in the completing cycle, the one with stallM=0.
- Memory array is not reset; contents are undefined until written.

## Timing
- Memory op entering M in cycle t with latency L=MEM_LATENCY:
  - stallM=1 in cycles t..t+L-1 (none if L=0).
  - Array written at the rising edge ending cycle t+L.
  - W outputs valid in cycle t+L+1.
- ALU ops, bubbles and misaligned ops reach W in cycle t+1.
- Back-to-back memory ops: the second is accepted in the cycle after the first completes, so there is no idle gap when L=0.
- A load immediately after a store to the same word returns the stored data.
- Reset, effective immediately regardless of clock:
  - W outputs all 0.
  - FSM to IDLE, cnt=0, stallM=0.
  - A store pending in WAIT is abandoned and never commits.
- Inputs must be stable while stallM=1. Changing them mid-WAIT is a protocol violation with undefined result.

## Test plan
- L=0: sw 0xDEADBEEF to 0x10, then lw 0x10 → cycle after the lw, readdataW=0xDEADBEEF, memtoregW=1, validW=1.
- L=0, word 0x10 holding 0xDEADBEEF:
  - sb 0x80 to 0x13 → lw 0x10 returns 0x80ADBEEF.
  - lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080.
  - sh 0x1234 to 0x10, then lhu 0x10 → 0x00001234.
- L=2: lw 0x20 → stallM high exactly 2 cycles, validW=0 during those cycles, data in W in cycle t+3. An add held behind it enters W in cycle t+4.
- lh 0x11 and lw 0x22 → misalignW=1, regwriteW=0, no stall cycles, memory unchanged on readback.
- L=3: sw 0xCAFEF00D to 0x30 with reset asserted in the second stall cycle → all W outputs 0 immediately, stallM=0. A subsequent lw 0x30 returns the prior value.
- L=0: ten back-to-back ALU ops with distinct aluoutM → aluoutW/writeregW track with 1-cycle delay, stallM never asserts. validM=0 cycles produce validW=0 and regwriteW=0.
